// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter serializing up to N ring requesters onto the single-port packet memory.
// Optional MEM_ARB_PRIO0_EN gives port 0 priority over the rotating ports 1..N-1.
module mem_bus_arbiter #(
  parameter int unsigned N          = 4,
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    wr,
  input  logic [N*AW-1:0] addr,
  input  logic [N*DW-1:0] wdata,
  output logic [N-1:0]    done,
  output logic [DW-1:0]   rdata,
  output logic [N-1:0]    grant,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_we,
  output logic            mem_rd,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(RD_LATENCY) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last, last_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic          is_wr, is_wr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  done_nxt, grant_nxt;
  logic [DW-1:0] rdata_nxt, mem_wdata_nxt, sel_wdata;
  logic [AW-1:0] mem_addr_nxt, sel_addr;
  logic          mem_we_nxt, mem_rd_nxt, sel_wr;
  logic          win_valid;
  logic [IW-1:0] win;
  int unsigned   scan;

`ifdef MEM_ARB_PRIO0_EN
  // Rotation pointer for ports 1..N-1; port 0 never advances it.
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic          oth_valid;
  logic [IW-1:0] oth;

  // Port 0 wins unless it was just served while another port waits, so it gets every other slot.
  always_comb begin
    oth_valid = 1'b0;
    oth       = '0;
    scan      = 0;
    for (int k = 1; k <= int'(N); k++) begin
      scan = (32'(rr_ptr) + 32'(k)) % N;
      if (!oth_valid && scan != 0 && req[IW'(scan)]) begin
        oth_valid = 1'b1;
        oth       = IW'(scan);
      end
    end
    win_valid = req[0] || oth_valid;
    win       = (req[0] && !(last == '0 && oth_valid)) ? '0 : oth;
  end
`else
  // Pure round robin: first requester after the last served port.
  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    scan      = 0;
    for (int k = 1; k <= int'(N); k++) begin
      scan = (32'(last) + 32'(k)) % N;
      if (!win_valid && req[IW'(scan)]) begin
        win_valid = 1'b1;
        win       = IW'(scan);
      end
    end
  end
`endif

  // Payload mux for the selected winner.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (win == IW'(i)) begin
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
        sel_wr    = wr[i];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    owner_nxt     = owner;
    is_wr_nxt     = is_wr;
    cnt_nxt       = cnt;
    done_nxt      = '0;
    grant_nxt     = grant;
    rdata_nxt     = rdata;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_we_nxt    = 1'b0;
    mem_rd_nxt    = 1'b0;
`ifdef MEM_ARB_PRIO0_EN
    rr_ptr_nxt    = rr_ptr;
`endif
    case (state)
      IDLE: begin
        if (win_valid) begin
          grant_nxt     = N'(1) << win;
          owner_nxt     = win;
          is_wr_nxt     = sel_wr;
          mem_addr_nxt  = sel_addr;
          mem_wdata_nxt = sel_wdata;
          mem_we_nxt    = sel_wr;
          mem_rd_nxt    = !sel_wr;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        if (is_wr) begin
          done_nxt  = N'(1) << owner;
          state_nxt = DONE;
        end else begin
          cnt_nxt   = CW'(RD_LATENCY - 1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          rdata_nxt = mem_rdata;
          done_nxt  = N'(1) << owner;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      DONE: begin
        last_nxt  = owner;
        grant_nxt = '0;
        state_nxt = IDLE;
`ifdef MEM_ARB_PRIO0_EN
        if (owner != '0) rr_ptr_nxt = owner;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state     <= IDLE;
      last      <= IW'(N - 1);
      owner     <= '0;
      is_wr     <= 1'b0;
      cnt       <= '0;
      done      <= '0;
      grant     <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_rd    <= 1'b0;
`ifdef MEM_ARB_PRIO0_EN
      rr_ptr    <= IW'(N - 1);
`endif
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      owner     <= owner_nxt;
      is_wr     <= is_wr_nxt;
      cnt       <= cnt_nxt;
      done      <= done_nxt;
      grant     <= grant_nxt;
      rdata     <= rdata_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_we    <= mem_we_nxt;
      mem_rd    <= mem_rd_nxt;
`ifdef MEM_ARB_PRIO0_EN
      rr_ptr    <= rr_ptr_nxt;
`endif
    end
  end

endmodule
